// File: rtl/hififo_ctrl_regs_if.sv
// PIO bus between pcie_rx/pcie_tx and the HIFIFO control register block.
// Write strobe, read request and read completion are grouped in one bundle.
interface hififo_ctrl_regs_if;
  // Handshakes: wr_valid is a one-cycle strobe with no back-pressure.
  // rr_valid is held with a stable rr_addr until the one-cycle rr_ready pulse.
  // rc_valid is held with a stable rc_data until sampled together with
  // rc_ready at a rising edge; the transfer happens at that edge.
  logic        wr_valid;
  logic [5:0]  wr_address;
  logic [63:0] wr_data;
  logic        rr_valid;
  logic        rr_ready;
  logic [7:0]  rr_addr;
  logic        rc_valid;
  logic        rc_ready;
  logic [31:0] rc_data;

  modport master (
    output wr_valid, wr_address, wr_data,
    output rr_valid, rr_addr, rc_ready,
    input  rr_ready, rc_valid, rc_data
  );

  modport slave (
    input  wr_valid, wr_address, wr_data,
    input  rr_valid, rr_addr, rc_ready,
    output rr_ready, rc_valid, rc_data
  );
endinterface

// File: rtl/hififo_ctrl_regs.sv
// HIFIFO control/status registers for NFIFO channels: PIO decode, read
// completions, maskable interrupt aggregation, per-FIFO soft reset.
// Optional macro HIFIFO_IRQ_MASK_EN implements the writable irq_mask register.
module hififo_ctrl_regs #(
  parameter int          NFIFO   = 8,
  parameter logic [15:0] ENABLE  = 16'h0011,
  parameter logic [15:0] VERSION = 16'h0002
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pci_reset,
  hififo_ctrl_regs_if.slave    bus,
  input  logic [32*NFIFO-1:0]  status,
  input  logic [2*NFIFO-1:0]   irq_in,
  output logic                 interrupt,
  input  logic                 interrupt_rdy,
  output logic [NFIFO-1:0]     fifo_reset,
  output logic [1:0]           rd_state
);
  localparam int IW = 2 * NFIFO;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_CAPTURE = 2'd1,
    RD_RESP    = 2'd2,
    RD_DONE    = 2'd3
  } rd_state_e;

  rd_state_e         state_q, state_d;
  logic [IW-1:0]     irq_status;
  logic [IW-1:0]     irq_mask;
  logic [IW-1:0]     irq_en;
  logic [IW-1:0]     irq_event;
  logic [IW-1:0]     irq_clr;
  logic [NFIFO-1:0]  ch_en;
  logic [NFIFO-1:0]  fifo_reset_d;
  logic [4:0]        rd_index;
  logic [31:0]       rd_mux;
  logic              rd_is_status;
  logic              wr_status, wr_set, wr_clr;
  logic              unused_bits;

  // Each channel owns two adjacent interrupt bits.
  assign ch_en = ENABLE[NFIFO-1:0];
  for (genvar g = 0; g < NFIFO; g++) begin : g_irq_en
    assign irq_en[2*g +: 2] = {2{ENABLE[g]}};
  end

  assign wr_status = bus.wr_valid && (bus.wr_address == 6'd0);
  assign wr_set    = bus.wr_valid && (bus.wr_address == 6'd3);
  assign wr_clr    = bus.wr_valid && (bus.wr_address == 6'd4);
  assign rd_index  = bus.rr_addr[5:1];
  assign unused_bits = &{1'b0, bus.rr_addr[7:6], bus.rr_addr[0], bus.wr_data[63:IW]};

`ifdef HIFIFO_IRQ_MASK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                       irq_mask <= '1;
    else if (pci_reset)                                 irq_mask <= '1;
    else if (bus.wr_valid && bus.wr_address == 6'd2)    irq_mask <= bus.wr_data[IW-1:0];
  end
`else
  assign irq_mask = '1;
`endif

  assign irq_event = irq_in & irq_mask & irq_en;

  // Read-clear takes exactly the captured bits; a same-cycle event still sets.
  always_comb begin
    irq_clr = '0;
    if (wr_status) irq_clr = irq_clr | bus.wr_data[IW-1:0];
    if (state_q == RD_RESP && bus.rc_ready && rd_is_status)
      irq_clr = irq_clr | bus.rc_data[IW-1:0];
  end

  always_comb begin
    fifo_reset_d = fifo_reset;
    if (wr_set) fifo_reset_d = fifo_reset_d | bus.wr_data[NFIFO-1:0];
    if (wr_clr) fifo_reset_d = fifo_reset_d & ~bus.wr_data[NFIFO-1:0];
    fifo_reset_d = fifo_reset_d | ~ch_en;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_status <= '0;
      interrupt  <= 1'b0;
      fifo_reset <= '1;
    end else if (pci_reset) begin
      irq_status <= '0;
      interrupt  <= 1'b0;
      fifo_reset <= '1;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | irq_event;
      interrupt  <= (interrupt & ~interrupt_rdy) | (|irq_event);
      fifo_reset <= fifo_reset_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_index)
      5'd0: rd_mux = 32'(irq_status);
      5'd1: rd_mux = 32'(ENABLE);
`ifdef HIFIFO_IRQ_MASK_EN
      5'd2: rd_mux = 32'(irq_mask);
`endif
      5'd3, 5'd4: rd_mux = 32'(fifo_reset);
      5'd5: rd_mux = {VERSION, 16'(NFIFO)};
      default: begin
        for (int i = 0; i < NFIFO; i++)
          if (rd_index == 5'(16 + i)) rd_mux = status[32*i +: 32];
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       state_q <= RD_IDLE;
    else if (pci_reset) state_q <= RD_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.rc_valid = 1'b0;
    bus.rr_ready = 1'b0;
    case (state_q)
      RD_IDLE:    if (bus.rr_valid) state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = RD_RESP;
      RD_RESP: begin
        bus.rc_valid = 1'b1;
        if (bus.rc_ready) state_d = RD_DONE;
      end
      RD_DONE: begin
        bus.rr_ready = 1'b1;
        state_d      = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign rd_state = state_q;

  // Completion payload is frozen at CAPTURE and held through the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rc_data  <= '0;
      rd_is_status <= 1'b0;
    end else if (pci_reset) begin
      bus.rc_data  <= '0;
      rd_is_status <= 1'b0;
    end else if (state_q == RD_CAPTURE) begin
      bus.rc_data  <= rd_mux;
      rd_is_status <= (rd_index == 5'd0);
    end
  end
endmodule

// File: tb/tb_hififo_ctrl_regs.sv
// Bench for hififo_ctrl_regs: directed scenarios then random traffic, read
// completions scored against a rule-level register model.
module tb_hififo_ctrl_regs;
  localparam int          NF      = 8;
  localparam int          IW      = 2 * NF;
  localparam logic [15:0] EN_MAP  = 16'h0011;
  localparam logic [15:0] VER     = 16'h0002;

  logic              clock, reset_n, pci_reset;
  logic [32*NF-1:0]  status;
  logic [IW-1:0]     irq_in;
  logic              interrupt, interrupt_rdy;
  logic [NF-1:0]     fifo_reset;
  logic [1:0]        rd_state;

  hififo_ctrl_regs_if bus();

  hififo_ctrl_regs #(.NFIFO(NF), .ENABLE(EN_MAP), .VERSION(VER)) dut (
    .clock(clock), .reset_n(reset_n), .pci_reset(pci_reset), .bus(bus),
    .status(status), .irq_in(irq_in), .interrupt(interrupt),
    .interrupt_rdy(interrupt_rdy), .fifo_reset(fifo_reset), .rd_state(rd_state)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  idx_q[$];
  int          sink_mode = 0;
  bit          bg_en = 0;
  bit          chk_en = 0;
  bit          got;

  // Reference model state
  logic [IW-1:0] m_status, m_mask, en_irq;
  logic [NF-1:0] m_fifo, en_ch;
  logic          m_pend;
  logic [15:0]   en_map_v;
  logic [IW-1:0] mon_clr_bits;
  int            mon_clr_cnt = 0;
  int            mdl_clr_seen = 0;
  logic [31:0]   mon_e;
  logic [4:0]    mon_i;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int idx);
    logic [31:0] r;
    r = '0;
    if (idx == 0)                   r = 32'(m_status);
    else if (idx == 1)              r = {16'h0, EN_MAP};
    else if (idx == 2) begin
`ifdef HIFIFO_IRQ_MASK_EN
      r = 32'(m_mask);
`endif
    end
    else if (idx == 3 || idx == 4)  r = 32'(m_fifo);
    else if (idx == 5)              r = {VER, 16'(NF)};
    else if (idx >= 16 && idx < 16 + NF) r = status[32*(idx-16) +: 32];
    return r;
  endfunction

  // Model: registers follow the written rules, updated at each rising edge.
  initial begin
    logic [IW-1:0] ev, clr;
    en_map_v = EN_MAP;
    en_ch = en_map_v[NF-1:0];
    for (int b = 0; b < IW; b++) en_irq[b] = en_map_v[b/2];
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n || pci_reset) begin
        m_status = '0; m_mask = '1; m_fifo = '1; m_pend = 1'b0;
        mdl_clr_seen = mon_clr_cnt;
      end else begin
        ev  = irq_in & m_mask & en_irq;
        clr = '0;
        if (bus.wr_valid && bus.wr_address == 6'd0) clr = bus.wr_data[IW-1:0];
        if (mon_clr_cnt != mdl_clr_seen) begin
          clr = clr | mon_clr_bits;
          mdl_clr_seen = mon_clr_cnt;
        end
        m_status = (m_status & ~clr) | ev;
`ifdef HIFIFO_IRQ_MASK_EN
        if (bus.wr_valid && bus.wr_address == 6'd2) m_mask = bus.wr_data[IW-1:0];
`endif
        if (bus.wr_valid && bus.wr_address == 6'd3) m_fifo = m_fifo | bus.wr_data[NF-1:0];
        if (bus.wr_valid && bus.wr_address == 6'd4) m_fifo = m_fifo & ~bus.wr_data[NF-1:0];
        m_fifo = m_fifo | ~en_ch;
        m_pend = (m_pend && !interrupt_rdy) || (ev != '0);
      end
    end
  end

  // Monitor: per-cycle interrupt/fifo_reset checks and completion scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("interrupt", 64'(interrupt), 64'(m_pend));
        chk("fifo_reset", 64'(fifo_reset), 64'(m_fifo));
        if (bus.rc_valid && bus.rc_ready) begin
          if (exp_q.size() == 0) chk("sb_extra", 64'(bus.rc_valid), 64'(0));
          else begin
            mon_e = exp_q.pop_front();
            mon_i = idx_q.pop_front();
            chk("rc_data", 64'(bus.rc_data), 64'(mon_e));
            if (mon_i == 5'd0) begin
              mon_clr_bits = mon_e[IW-1:0];
              mon_clr_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    bus.rc_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (sink_mode == 0)      bus.rc_ready = 1'b0;
      else if (sink_mode == 1) bus.rc_ready = ($urandom_range(0, 2) != 0);
      else                     bus.rc_ready = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clock);
    if (bg_en) begin
      irq_in = IW'($urandom) & IW'($urandom) & IW'($urandom);
      interrupt_rdy = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [63:0] data);
    tick();
    bus.wr_valid = 1'b1; bus.wr_address = addr; bus.wr_data = data;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] idx, input bit pulse0);
    bit seen;
    seen = 1'b0;
    tick();
    bus.rr_valid = 1'b1;
    bus.rr_addr  = {2'($urandom), idx, 1'($urandom)};
    tick();
    exp_q.push_back(model_read(int'(idx)));
    idx_q.push_back(idx);
    chk("rc_valid_capture", 64'(bus.rc_valid), 64'(0));
    tick();
    chk("rc_valid_resp", 64'(bus.rc_valid), 64'(1));
    if (pulse0) begin
      irq_in = IW'(1);
      tick();
      irq_in = '0;
      sink_mode = 2;
    end
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      seen = bus.rr_ready;
    end
    chk("rr_ready_seen", 64'(seen), 64'(1));
    bus.rr_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pci_reset = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_address = '0; bus.wr_data = '0;
    bus.rr_valid = 1'b0; bus.rr_addr = '0;
    irq_in = '0; interrupt_rdy = 1'b0;
    for (int i = 0; i < NF; i++) status[32*i +: 32] = $urandom;
    repeat (3) @(negedge clock);
    chk("rst_rc_valid", 64'(bus.rc_valid), 64'(0));
    chk("rst_rr_ready", 64'(bus.rr_ready), 64'(0));
    chk("rst_rc_data", 64'(bus.rc_data), 64'(0));
    chk("rst_interrupt", 64'(interrupt), 64'(0));
    chk("rst_fifo_reset", 64'(fifo_reset), 64'hFF);
    chk("rst_rd_state", 64'(rd_state), 64'(0));
    reset_n = 1'b1;
    chk_en = 1'b1;
    sink_mode = 1;

    do_read(5'd3, 1'b0); chk("rd_fifo_reset", 64'(bus.rc_data), 64'h000000FF);
    do_read(5'd5, 1'b0); chk("rd_version", 64'(bus.rc_data), 64'h00020008);
    do_read(5'd1, 1'b0); chk("rd_enable", 64'(bus.rc_data), 64'h00000011);
    do_read(5'd18, 1'b0);
    do_read(5'd9, 1'b0); chk("rd_hole", 64'(bus.rc_data), 64'(0));

    do_write(6'd4, 64'h11);
    do_write(6'd3, 64'h10);
    chk("fifo_fe", 64'(fifo_reset), 64'hFE);
    do_read(5'd4, 1'b0); chk("rd_fifo_fe", 64'(bus.rc_data), 64'hFE);

    tick(); irq_in = IW'(1) << 8;
    tick(); irq_in = '0;
    chk("irq_raise", 64'(interrupt), 64'(1));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("irq_hold", 64'(interrupt), 64'(1));
    end
    interrupt_rdy = 1'b1;
    tick(); interrupt_rdy = 1'b0;
    chk("irq_ack", 64'(interrupt), 64'(0));

    sink_mode = 0;
    do_read(5'd0, 1'b1); chk("rd_irq_status", 64'(bus.rc_data), 64'h100);
    sink_mode = 1;
    do_read(5'd0, 1'b0); chk("rd_irq_after_clr", 64'(bus.rc_data), 64'h1);

    interrupt_rdy = 1'b1;
    tick(); interrupt_rdy = 1'b0;
    do_read(5'd0, 1'b0);
    do_write(6'd2, 64'h0);
`ifdef HIFIFO_IRQ_MASK_EN
    tick(); irq_in = IW'(1);
    tick(); irq_in = '0;
    chk("mask_blocks_irq", 64'(interrupt), 64'(0));
    do_read(5'd0, 1'b0); chk("mask_status", 64'(bus.rc_data), 64'(0));
    do_read(5'd2, 1'b0); chk("mask_read", 64'(bus.rc_data), 64'(0));
    do_write(6'd2, 64'hFFFF);
`else
    do_read(5'd2, 1'b0); chk("mask_read", 64'(bus.rc_data), 64'(0));
    tick(); irq_in = IW'(1);
    tick(); irq_in = '0;
    chk("mask_const_irq", 64'(interrupt), 64'(1));
    do_read(5'd0, 1'b0); chk("mask_status", 64'(bus.rc_data), 64'h1);
`endif

    sink_mode = 0;
    tick();
    bus.rr_valid = 1'b1; bus.rr_addr = 8'h02;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = bus.rc_valid;
    end
    chk("abort_resp_seen", 64'(got), 64'(1));
    pci_reset = 1'b1; bus.rr_valid = 1'b0;
    tick(); pci_reset = 1'b0;
    chk("abort_rc_valid", 64'(bus.rc_valid), 64'(0));
    chk("abort_rc_data", 64'(bus.rc_data), 64'(0));
    chk("abort_rd_state", 64'(rd_state), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_rr_ready", 64'(bus.rr_ready), 64'(0));
      tick();
    end
    sink_mode = 1;
    do_read(5'd5, 1'b0); chk("post_abort_read", 64'(bus.rc_data), 64'h00020008);

    bg_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [5:0] wa;
      case ($urandom_range(0, 5))
        0: wa = 6'd0;
        1: wa = 6'd2;
        2: wa = 6'd3;
        3: wa = 6'd4;
        default: wa = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 2) != 0) do_read(5'($urandom_range(0, 31)), 1'b0);
      else do_write(wa, {$urandom, $urandom});
    end
    bg_en = 1'b0;
    irq_in = '0; interrupt_rdy = 1'b0;
    sink_mode = 2;
    repeat (10) tick();
    chk("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
